// File: rtl/gate_sweep_checker_pkg.sv
// ---------------------------------------------------------------------------
// gate_sweep_pkg
// Shared constants for the gate sweep self-test: bit positions of each gate
// on the eight-bit gate bus, the sweep FSM encoding, the number of {a,b}
// input vectors and a popcount helper used to tally mismatching bits.
// No ports (package only).
// ---------------------------------------------------------------------------
package gate_sweep_pkg;

    localparam int GATE_W      = 8;
    localparam int NUM_VECTORS = 4;

    // Bit positions of each gate output on the gate bus
    localparam int GB_BUF  = 0;
    localparam int GB_AND  = 1;
    localparam int GB_OR   = 2;
    localparam int GB_XOR  = 3;
    localparam int GB_NOT  = 4;
    localparam int GB_NAND = 5;
    localparam int GB_NOR  = 6;
    localparam int GB_XNOR = 7;

    // Sweep FSM encoding, kept as plain constants so older tools that
    // dislike enums in port-facing logic can still read the state register
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Counts the ones in a gate-bus-wide word; 0..8 fits in four bits
    function automatic logic [3:0] popcount8(input logic [GATE_W-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < GATE_W; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// ---------------------------------------------------------------------------
// gate_sweep_checker_if
// Bundles the checker's control, gate-block and status signals.
//   start      controller -> checker, level request to begin a sweep
//   a, b       checker -> gate block inputs
//   gate_bus   gate block -> checker, eight gate outputs
//   busy/done  checker status (sweeping / one-cycle completion pulse)
//   pass, err_count, fail_mask, fail_vec   results of the last sweep
// Modport slave is the checker's view, master is the surrounding board's.
// ---------------------------------------------------------------------------
interface gate_sweep_checker_if #(
    parameter int ERR_W = 6
) ();
    import gate_sweep_pkg::*;

    logic              start;
    logic              a;
    logic              b;
    logic [GATE_W-1:0] gate_bus;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic [GATE_W-1:0] fail_mask;
    logic [3:0]        fail_vec;

    modport slave (
        input  start, gate_bus,
        output a, b, busy, done, pass, err_count, fail_mask, fail_vec
    );

    modport master (
        output start, gate_bus,
        input  a, b, busy, done, pass, err_count, fail_mask, fail_vec
    );

endinterface

// File: rtl/gate_sweep_checker_golden.sv
// ---------------------------------------------------------------------------
// gate_golden_model
// Combinational reference for the two-input gate block.
//   a_i, b_i     current sweep vector
//   expected_o   what each gate output should be for that vector
// ---------------------------------------------------------------------------
module gate_golden_model
    import gate_sweep_pkg::*;
(
    input  logic              a_i,
    input  logic              b_i,
    output logic [GATE_W-1:0] expected_o
);

    // One entry per gate; inverted gates are derived from their base forms
    always_comb begin
        expected_o          = '0;
        expected_o[GB_BUF]  = a_i;
        expected_o[GB_AND]  = a_i & b_i;
        expected_o[GB_OR]   = a_i | b_i;
        expected_o[GB_XOR]  = a_i ^ b_i;
        expected_o[GB_NOT]  = ~b_i;
        expected_o[GB_NAND] = ~(a_i & b_i);
        expected_o[GB_NOR]  = ~(a_i | b_i);
        expected_o[GB_XNOR] = ~(a_i ^ b_i);
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// gate_sweep_checker
// Self-test stage around the two-input gate block. On an accepted start it
// walks {a,b} through 00,01,10,11, holds each for SETTLE_CYCLES cycles,
// samples the gate bus for one cycle and compares it to the golden model.
//   clk, rst_n   system clock and asynchronous active-low reset
//   bus          gate_sweep_checker_if.slave (start, a/b, gate_bus, status)
// Parameters: SETTLE_CYCLES (>=1), ERR_W (saturating mismatch counter width)
// ---------------------------------------------------------------------------
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_sweep_checker_if.slave   bus
);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("gate_sweep_checker: SETTLE_CYCLES must be >= 1");
    end

    // The settle counter only needs to hold SETTLE_CYCLES-1
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    // One extra bit over the wider operand so the add cannot overflow
    localparam int SUM_W = ((ERR_W > 4) ? ERR_W : 4) + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  settleCnt_q, settleCnt_d;
    logic [1:0]        vecIdx_q,    vecIdx_d;
    logic [ERR_W-1:0]  errCount_q,  errCount_d;
    logic [GATE_W-1:0] failMask_q,  failMask_d;
    logic [3:0]        failVec_q,   failVec_d;
    logic              pass_q,      pass_d;

    logic [GATE_W-1:0] expected;
    logic [GATE_W-1:0] mism;
    logic [3:0]        popCnt;
    logic [SUM_W-1:0]  errSum;
    logic [ERR_W-1:0]  errSat;

    // The vector index doubles as the registered {a,b} drive
    gate_golden_model u_golden (
        .a_i        (vecIdx_q[1]),
        .b_i        (vecIdx_q[0]),
        .expected_o (expected)
    );

    // Mismatch tally for the current vector, clamped at the counter maximum
    always_comb begin
        mism   = bus.gate_bus ^ expected;
        popCnt = popcount8(mism);
        errSum = SUM_W'(errCount_q) + SUM_W'(popCnt);
        errSat = (errSum > SUM_W'(ERR_MAX)) ? ERR_MAX : errSum[ERR_W-1:0];
    end

    // Sweep sequencing; results only change on accept or in SAMPLE, so they
    // hold in IDLE until the next start. pass is decided on the edge into
    // DONE so it is already valid during the done pulse.
    always_comb begin
        state_d     = state_q;
        settleCnt_d = settleCnt_q;
        vecIdx_d    = vecIdx_q;
        errCount_d  = errCount_q;
        failMask_d  = failMask_q;
        failVec_d   = failVec_q;
        pass_d      = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_SETTLE;
                    settleCnt_d = SETTLE_LOAD;
                    vecIdx_d    = 2'd0;
                    errCount_d  = '0;
                    failMask_d  = '0;
                    failVec_d   = '0;
                    pass_d      = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (settleCnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settleCnt_d = settleCnt_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                errCount_d          = errSat;
                failMask_d          = failMask_q | mism;
                failVec_d[vecIdx_q] = |mism;
                vecIdx_d            = vecIdx_q + 2'd1;
                if (vecIdx_q == 2'(NUM_VECTORS - 1)) begin
                    state_d = ST_DONE;
                    pass_d  = (errSat == '0);
                end else begin
                    state_d     = ST_SETTLE;
                    settleCnt_d = SETTLE_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All sweep state clears asynchronously so a mid-sweep reset drops a/b
    // and status immediately with no done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            settleCnt_q <= '0;
            vecIdx_q    <= 2'd0;
            errCount_q  <= '0;
            failMask_q  <= '0;
            failVec_q   <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            settleCnt_q <= settleCnt_d;
            vecIdx_q    <= vecIdx_d;
            errCount_q  <= errCount_d;
            failMask_q  <= failMask_d;
            failVec_q   <= failVec_d;
            pass_q      <= pass_d;
        end
    end

    // Status is decoded straight from registered state
    always_comb begin
        bus.a         = vecIdx_q[1];
        bus.b         = vecIdx_q[0];
        bus.busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
        bus.done      = (state_q == ST_DONE);
        bus.pass      = pass_q;
        bus.err_count = errCount_q;
        bus.fail_mask = failMask_q;
        bus.fail_vec  = failVec_q;
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_sweep_checker
// Directed bench for gate_sweep_checker. Two instances: a default ERR_W=6
// checker fed by a modelled gate block with selectable faults, and an
// ERR_W=4 checker fed by a fully inverted gate bus for saturation.
// ---------------------------------------------------------------------------
module tb_gate_sweep_checker;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   mode;
    logic corrupt;

    gate_sweep_checker_if #(.ERR_W(6)) bus6 ();
    gate_sweep_checker_if #(.ERR_W(4)) bus4 ();

    gate_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(6)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // Bench-side model of a healthy gate block, bit order BUF..XNOR
    function automatic logic [7:0] gold(input logic a, input logic b);
        return {~(a ^ b), ~(a | b), ~(a & b), ~b, a ^ b, a | b, a & b, a};
    endfunction

    // Fault injection: 0 healthy, 1 AND stuck-at-0, 2 all inverted,
    // 3 inverted whenever corrupt is set
    always_comb begin
        case (mode)
            1:       bus6.gate_bus = gold(bus6.a, bus6.b) & 8'hFD;
            2:       bus6.gate_bus = ~gold(bus6.a, bus6.b);
            3:       bus6.gate_bus = gold(bus6.a, bus6.b) ^ {8{corrupt}};
            default: bus6.gate_bus = gold(bus6.a, bus6.b);
        endcase
        bus4.gate_bus = ~gold(bus4.a, bus4.b);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus6.start = 1'b0;
        bus4.start = 1'b0;
        mode       = 0;
        corrupt    = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus6.a, bus6.b, bus6.busy, bus6.done, bus6.pass, bus6.err_count,
             bus6.fail_mask, bus6.fail_vec} !== 25'd0) begin
            failures++;
            $display("[TB] FAIL reset6 got=%0h exp=0", {bus6.a, bus6.b, bus6.busy,
                     bus6.done, bus6.pass, bus6.err_count, bus6.fail_mask, bus6.fail_vec});
        end
        checks++;
        if ({bus4.busy, bus4.done, bus4.pass, bus4.err_count} !== 7'd0) begin
            failures++;
            $display("[TB] FAIL reset4 got=%0h exp=0",
                     {bus4.busy, bus4.done, bus4.pass, bus4.err_count});
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Healthy block: vector order, 3-cycle hold, busy window, done at k+13
    task automatic test_sweep_pass();
        mode       = 0;
        bus6.start = 1'b1;
        tick();
        bus6.start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if ({bus6.busy, bus6.done, bus6.a, bus6.b} !== {2'b10, 2'(c / 3)}) begin
                failures++;
                $display("[TB] FAIL sweep_c%0d busy/done/ab got=%b exp=%b", c,
                         {bus6.busy, bus6.done, bus6.a, bus6.b}, {2'b10, 2'(c / 3)});
            end
            tick();
        end
        checks++;
        if ({bus6.busy, bus6.done, bus6.pass, bus6.a, bus6.b} !== 5'b01100) begin
            failures++;
            $display("[TB] FAIL done_pulse got=%b exp=01100",
                     {bus6.busy, bus6.done, bus6.pass, bus6.a, bus6.b});
        end
        checks++;
        if ({bus6.err_count, bus6.fail_mask, bus6.fail_vec} !== 18'd0) begin
            failures++;
            $display("[TB] FAIL pass_results got=%0h exp=0",
                     {bus6.err_count, bus6.fail_mask, bus6.fail_vec});
        end
        tick();
        tick();
        checks++;
        if ({bus6.busy, bus6.done, bus6.pass} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL idle_hold got=%b exp=001", {bus6.busy, bus6.done, bus6.pass});
        end
    endtask

    task automatic test_and_stuck();
        mode       = 1;
        bus6.start = 1'b1;
        tick();
        bus6.start = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        checks++;
        if ({bus6.done, bus6.pass, bus6.err_count, bus6.fail_mask, bus6.fail_vec}
                !== {1'b1, 1'b0, 6'd1, 8'h02, 4'b1000}) begin
            failures++;
            $display("[TB] FAIL and_stuck got done=%b pass=%b err=%0d mask=%h vec=%b exp 1 0 1 02 1000",
                     bus6.done, bus6.pass, bus6.err_count, bus6.fail_mask, bus6.fail_vec);
        end
        tick();
    endtask

    // Every bit wrong: 32 mismatches, clamps to 15 on the narrow counter
    task automatic test_saturation();
        mode       = 2;
        bus6.start = 1'b1;
        bus4.start = 1'b1;
        tick();
        bus6.start = 1'b0;
        bus4.start = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        checks++;
        if ({bus4.done, bus4.pass, bus4.err_count, bus4.fail_mask, bus4.fail_vec}
                !== {1'b1, 1'b0, 4'd15, 8'hFF, 4'hF}) begin
            failures++;
            $display("[TB] FAIL saturate4 got done=%b pass=%b err=%0d mask=%h vec=%h exp 1 0 15 ff f",
                     bus4.done, bus4.pass, bus4.err_count, bus4.fail_mask, bus4.fail_vec);
        end
        checks++;
        if (bus6.err_count !== 6'd32) begin
            failures++;
            $display("[TB] FAIL count32 got=%0d exp=32", bus6.err_count);
        end
        tick();
    endtask

    // Garbage everywhere except the SAMPLE cycle of each vector
    task automatic test_settle_glitch();
        mode       = 3;
        corrupt    = 1'b1;
        bus6.start = 1'b1;
        tick();
        bus6.start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            corrupt = ((c % 3) != 2);
            tick();
        end
        corrupt = 1'b1;
        checks++;
        if ({bus6.done, bus6.pass, bus6.err_count} !== {2'b11, 6'd0}) begin
            failures++;
            $display("[TB] FAIL settle_glitch got done=%b pass=%b err=%0d exp 1 1 0",
                     bus6.done, bus6.pass, bus6.err_count);
        end
        tick();
        mode = 0;
    endtask

    task automatic test_reset_mid();
        mode       = 2;
        bus6.start = 1'b1;
        tick();
        bus6.start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus6.a, bus6.b, bus6.busy, bus6.done, bus6.pass, bus6.err_count,
             bus6.fail_mask, bus6.fail_vec} !== 25'd0) begin
            failures++;
            $display("[TB] FAIL mid_reset got=%0h exp=0", {bus6.a, bus6.b, bus6.busy,
                     bus6.done, bus6.pass, bus6.err_count, bus6.fail_mask, bus6.fail_vec});
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            checks++;
            if ({bus6.busy, bus6.done, bus6.a, bus6.b} !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL post_reset_c%0d got=%b exp=0000", c,
                         {bus6.busy, bus6.done, bus6.a, bus6.b});
            end
        end
        mode = 0;
    endtask

    // Start held high: done at c=12, one idle cycle, next busy from c=14
    task automatic test_back_to_back();
        logic expBusy;
        logic expDone;
        bus6.start = 1'b1;
        tick();
        for (int c = 0; c < 28; c++) begin
            expBusy = (c <= 11) || (c >= 14 && c <= 25);
            expDone = (c == 12) || (c == 26);
            checks++;
            if ({bus6.busy, bus6.done} !== {expBusy, expDone}) begin
                failures++;
                $display("[TB] FAIL b2b_c%0d busy/done got=%b exp=%b", c,
                         {bus6.busy, bus6.done}, {expBusy, expDone});
            end
            if (c == 27) bus6.start = 1'b0;
            tick();
        end
        checks++;
        if (bus6.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_stop got=%b exp=0", bus6.busy);
        end
    endtask

    // start toggling during busy and high in DONE must not disturb timing
    task automatic test_start_ignored();
        bus6.start = 1'b1;
        tick();
        for (int c = 0; c < 15; c++) begin
            checks++;
            if ({bus6.busy, bus6.done} !== {(c <= 11), (c == 12)}) begin
                failures++;
                $display("[TB] FAIL ignore_c%0d busy/done got=%b exp=%b", c,
                         {bus6.busy, bus6.done}, {(c <= 11), (c == 12)});
            end
            bus6.start = (c <= 12) ? ~bus6.start : 1'b0;
            if (c == 12) bus6.start = 1'b1;
            tick();
        end
        bus6.start = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sweep_pass();
        test_and_stuck();
        test_saturation();
        test_settle_glitch();
        test_reset_mid();
        test_back_to_back();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
